// File: rtl/bit_count_pkg.sv
// ----------------------------------------------------------------------------
// bit_count_pkg
// Shared types and helpers for the bit_count_unit popcount engine.
//   bc_state_t : controller states (IDLE, COUNT, DONE)
//   bc_cw()    : result width needed to hold a count of 0..width
// No ports (package).
// ----------------------------------------------------------------------------
package bit_count_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} bc_state_t;

    // A count can reach the full width itself, hence width+1 codes.
    function automatic int bc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_count_datapath.sv
// ----------------------------------------------------------------------------
// bit_count_datapath
// Storage for the popcount engine: the shifting operand copy (data), the
// running count (result) and the bit-position counter (cnt).
// Build option: BIT_COUNT_EARLY_EXIT_EN removes the position counter, since
// the early-exit controller finishes on an empty operand instead.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   load_data/operand : load the (already mode-adjusted) operand, clear cnt
//   shift_data        : shift data right by one, zero fill
//   clr_result        : clear result
//   inc_result        : add one to result
//   inc_cnt           : advance the bit-position counter
//   lsb               : data[0]
//   data_zero         : data has no ones left
//   cnt_last          : cnt is on the final bit position
//   result            : running / final count
// ----------------------------------------------------------------------------
module bit_count_datapath
    import bit_count_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = bc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_data,
    input  logic [WIDTH-1:0] operand,
    input  logic             shift_data,
    input  logic             clr_result,
    input  logic             inc_result,
    input  logic             inc_cnt,
    output logic             lsb,
    output logic             data_zero,
    output logic             cnt_last,
    output logic [CW-1:0]    result
);

    localparam int CNTW = $clog2(WIDTH);

    logic [WIDTH-1:0] data;

    // Operand copy: loaded at launch, then consumed one bit per cycle from
    // the bottom so only data[0] ever needs inspecting.
    always_ff @(posedge clk) begin
        if (reset)
            data <= '0;
        else if (load_data)
            data <= operand;
        else if (shift_data)
            data <= data >> 1;
    end

    // Running count; clearing takes priority so a launch always starts at 0.
    always_ff @(posedge clk) begin
        if (reset || clr_result)
            result <= '0;
        else if (inc_result)
            result <= result + CW'(1);
    end

    assign lsb       = data[0];
    assign data_zero = (data == '0);

`ifdef BIT_COUNT_EARLY_EXIT_EN
    // Early exit needs no position counter; the strobe is deliberately ignored.
    logic unused_inc_cnt;
    assign unused_inc_cnt = inc_cnt;
    assign cnt_last       = 1'b0;
`else
    logic [CNTW-1:0] cnt;

    // Bit position counter; restarts at each launch so the controller can
    // leave COUNT after exactly WIDTH bits.
    always_ff @(posedge clk) begin
        if (reset || load_data)
            cnt <= '0;
        else if (inc_cnt)
            cnt <= cnt + CNTW'(1);
    end

    assign cnt_last = (cnt == CNTW'(WIDTH - 1));
`endif

endmodule

// File: rtl/bit_count_unit.sv
// ----------------------------------------------------------------------------
// bit_count_unit
// Serial popcount engine with a start/done handshake. Counts the ones of A
// (mode=0) or the zeros of A (mode=1), one bit per clock.
// Build option: define BIT_COUNT_EARLY_EXIT_EN to leave COUNT as soon as no
// ones remain; otherwise every count takes exactly WIDTH cycles.
// Ports:
//   clk    : clock (rising edge)
//   reset  : synchronous active-high reset
//   s      : start level, launches one count from IDLE
//   A      : operand, sampled on the launch edge
//   mode   : 0 = count ones, 1 = count zeros, sampled on the launch edge
//   result : count, valid while done=1 (0 in IDLE)
//   busy   : counting in progress
//   done   : result ready; held until s drops
// ----------------------------------------------------------------------------
module bit_count_unit
    import bit_count_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = bc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [WIDTH-1:0] A,
    input  logic             mode,
    output logic [CW-1:0]    result,
    output logic             busy,
    output logic             done
);

    bc_state_t ps, ns;

    logic             load_data, shift_data, clr_result, inc_result, inc_cnt;
    logic             lsb, data_zero, cnt_last;
    logic [WIDTH-1:0] operand;

    // Counting zeros is counting ones of the inverted operand.
    assign operand = mode ? ~A : A;

    bit_count_datapath #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_datapath (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .operand    (operand),
        .shift_data (shift_data),
        .clr_result (clr_result),
        .inc_result (inc_result),
        .inc_cnt    (inc_cnt),
        .lsb        (lsb),
        .data_zero  (data_zero),
        .cnt_last   (cnt_last),
        .result     (result)
    );

`ifdef BIT_COUNT_EARLY_EXIT_EN
    logic unused_cnt_last;
    assign unused_cnt_last = cnt_last;
`else
    logic unused_data_zero;
    assign unused_data_zero = data_zero;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            ps <= IDLE;
        else
            ps <= ns;
    end

    // Next-state logic. DONE waits for s to drop so a held start yields
    // exactly one count.
    always_comb begin
        ns = ps;
        case (ps)
            IDLE:  if (s) ns = COUNT;
`ifdef BIT_COUNT_EARLY_EXIT_EN
            COUNT: if (data_zero) ns = DONE;
`else
            COUNT: if (cnt_last) ns = DONE;
`endif
            DONE:  if (!s) ns = IDLE;
            default: ns = IDLE;
        endcase
    end

    // Moore status outputs and datapath strobes.
    always_comb begin
        busy       = (ps == COUNT);
        done       = (ps == DONE);
        load_data  = 1'b0;
        shift_data = 1'b0;
        clr_result = 1'b0;
        inc_result = 1'b0;
        inc_cnt    = 1'b0;
        case (ps)
            IDLE: begin
                clr_result = 1'b1;
                load_data  = s;
            end
            COUNT: begin
`ifdef BIT_COUNT_EARLY_EXIT_EN
                // The empty-operand cycle only exits; nothing is counted.
                if (!data_zero) begin
                    shift_data = 1'b1;
                    inc_result = lsb;
                end
`else
                shift_data = 1'b1;
                inc_result = lsb;
                inc_cnt    = 1'b1;
`endif
            end
            DONE: begin
                clr_result = !s;
            end
            default: ;
        endcase
    end

endmodule
